// File: rtl/mux4_sel_pkg.sv
// rtl/mux4_sel_pkg.sv - select-code constants and helpers shared by the mux4_sel block
//
// Purpose: single source for the 4-bit select encodings, the default data
//          width and the illegal-select predicate.
// Ports:   none (package).

package mux4_sel_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [3:0] SEL_D0  = 4'h0;
   localparam logic [3:0] SEL_D1  = 4'h1;
   localparam logic [3:0] SEL_D2  = 4'h2;
   localparam logic [3:0] SEL_D3  = 4'h3;
   localparam logic [3:0] SEL_MAX = 4'h3;

   // Codes above SEL_MAX have no data input behind them.
   function automatic logic sel_illegal(input logic [3:0] code);
      return (code > SEL_MAX);
   endfunction

endpackage

// File: rtl/mux4_sel_reg.sv
// rtl/mux4_sel_reg.sv - WIDTH+1-bit capture register with asynchronous active-high clear
//
// Purpose: holds the registered copy of the selected data plus its
//          illegal-select flag for pipelined or debug consumers.
// Ports:
//   clk  in   1          rising-edge capture clock
//   rst  in   1          asynchronous active-high clear
//   d    in   WIDTH+1    {sel_err, output_data} to capture
//   q    out  WIDTH+1    captured value

module mux4_sel_reg
   import mux4_sel_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH:0]   d,
   output logic [WIDTH:0]   q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mux4_sel.sv
// rtl/mux4_sel.sv - four-way datapath selector with registered copy and illegal-select flag
//
// Purpose: routes one of four WIDTH-bit inputs to output_data under a 4-bit
//          select code with zero latency; a one-cycle registered copy and an
//          illegal-select flag are provided alongside.
// Ports:
//   clk            in   1      rising-edge clock (registered copy only)
//   rst            in   1      asynchronous active-high clear of registered outputs
//   d0..d3         in   WIDTH  data inputs, selected by codes 0x0..0x3
//   signal         in   4      binary select code
//   output_data    out  WIDTH  combinational selected data (0 for illegal codes)
//   sel_err        out  1      combinational, high when signal > 0x3
//   output_data_q  out  WIDTH  output_data registered on posedge clk
//   sel_err_q      out  1      sel_err registered on posedge clk

module mux4_sel
   import mux4_sel_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [3:0]       signal,
   output logic [WIDTH-1:0] output_data,
   output logic             sel_err,
   output logic [WIDTH-1:0] output_data_q,
   output logic             sel_err_q
);

   logic [WIDTH:0] reg_d;
   logic [WIDTH:0] reg_q;

   // The default arm covers both illegal codes and X/Z selects, so the
   // output is always driven and no latch can form.
   always_comb begin
      output_data = '0;
      case (signal)
         SEL_D0:  output_data = d0;
         SEL_D1:  output_data = d1;
         SEL_D2:  output_data = d2;
         SEL_D3:  output_data = d3;
         default: output_data = '0;
      endcase
   end

   assign sel_err = sel_illegal(signal);

   assign reg_d = {sel_err, output_data};

   mux4_sel_reg #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk (clk),
      .rst (rst),
      .d   (reg_d),
      .q   (reg_q)
   );

   assign sel_err_q     = reg_q[WIDTH];
   assign output_data_q = reg_q[WIDTH-1:0];

endmodule

// File: tb/tb_mux4_sel.sv
// tb/tb_mux4_sel.sv - self-checking bench for mux4_sel
//
// Purpose: directed stimulus with a scoreboard of expected selections,
//          compared one clock edge after each apply, plus direct checks of
//          mid-cycle data changes and asynchronous reset.
// Ports:   none (top-level bench).

module tb_mux4_sel;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] d0, d1, d2, d3;
   logic [3:0]   signal;
   logic [W-1:0] output_data;
   logic         sel_err;
   logic [W-1:0] output_data_q;
   logic         sel_err_q;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   mux4_sel #(
      .WIDTH (W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .d0            (d0),
      .d1            (d1),
      .d2            (d2),
      .d3            (d3),
      .signal        (signal),
      .output_data   (output_data),
      .sel_err       (sel_err),
      .output_data_q (output_data_q),
      .sel_err_q     (sel_err_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one selection, record the expected result, then after the next
   // rising edge compare both the combinational and registered outputs.
   task automatic apply(input string tag, input logic [3:0] s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] e);
      exp_t x;
      exp_t got;
      signal = s;
      d0 = a; d1 = b; d2 = c; d3 = e;
      case (s)
         4'h0:    x.data = a;
         4'h1:    x.data = b;
         4'h2:    x.data = c;
         4'h3:    x.data = e;
         default: x.data = '0;
      endcase
      x.err = (s >= 4'h4);
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, "_data"},   output_data,           got.data);
         chk({tag, "_err"},    {31'd0, sel_err},      {31'd0, got.err});
         chk({tag, "_data_q"}, output_data_q,         got.data);
         chk({tag, "_err_q"},  {31'd0, sel_err_q},    {31'd0, got.err});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      signal = 4'h0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      #2;
      chk("reset_data_q", output_data_q, 32'h0);
      chk("reset_err_q",  {31'd0, sel_err_q}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Walk all four legal codes with distinct data.
      for (int i = 0; i < 4; i++) begin
         apply($sformatf("walk%0d", i), 4'(i),
               32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      end

      // All-zero and all-ones boundaries.
      apply("zeros", 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      apply("ones",  4'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0);

      // Illegal selects with nonzero data.
      apply("ill4", 4'h4, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4);
      apply("ill8", 4'h8, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4);
      apply("illF", 4'hF, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4);

      // Equal inputs: output is just that value.
      apply("equal", 4'h3, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);

      // Mid-cycle data change: combinational follows, register waits for the edge.
      apply("d1_first", 4'h1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
      d1 = 32'hCAFEBABE;
      #2;
      chk("d1_comb_follow", output_data,   32'hCAFEBABE);
      chk("d1_q_hold",      output_data_q, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("d1_q_update",    output_data_q, 32'hCAFEBABE);

      // Asynchronous reset mid-cycle.
      apply("pre_rst", 4'h0, 32'h12345678, 32'h0, 32'h0, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_data_q", output_data_q,      32'h0);
      chk("rst_async_err_q",  {31'd0, sel_err_q}, 32'h0);
      chk("rst_comb_keep",    output_data,        32'h12345678);
      @(posedge clk);
      #1;
      chk("rst_hold_data_q",  output_data_q,      32'h0);
      chk("rst_comb_keep2",   output_data,        32'h12345678);

      // Release reset; capture resumes at the first edge after release.
      rst = 1'b0;
      signal = 4'h3;
      d3 = 32'hA5A5A5A5;
      #2;
      chk("rel_before_edge", output_data_q, 32'h0);
      @(posedge clk);
      #1;
      chk("rel_capture",     output_data_q, 32'hA5A5A5A5);
      chk("rel_err_q",       {31'd0, sel_err_q}, 32'h0);

      // Reset also clears a captured illegal-select flag.
      apply("ill_pre_rst", 4'h9, 32'h1, 32'h2, 32'h3, 32'h4);
      rst = 1'b1;
      #1;
      chk("rst_clear_err_q", {31'd0, sel_err_q}, 32'h0);
      chk("rst_comb_err",    {31'd0, sel_err},   32'h1);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mux4_sel.md
Name: mux4_sel

Overview:
- Datapath selector: routes one of four WIDTH-bit data inputs to the output under a 4-bit select code.
- Used in the MIPS monocycle datapath for PC-source, ALU-operand and writeback selection.
- Primary output is purely combinational, so the single-cycle timing is unaffected.
- A registered copy plus an illegal-select flag are provided for pipelined or debug consumers.

Parameters:
- WIDTH, 32, width of each data input and of the output.

Ports:
- clk  input  1  system clock, rising-edge active; used only by the registered copy.
- rst  input  1  asynchronous, active-high reset; clears the registered outputs only.
- d0  input  WIDTH  data input, selected by code 0x0.
- d1  input  WIDTH  data input, selected by code 0x1.
- d2  input  WIDTH  data input, selected by code 0x2.
- d3  input  WIDTH  data input, selected by code 0x3.
- signal  input  4  binary select code.
- output_data  output  WIDTH  combinational selected data.
- sel_err  output  1  combinational; high when signal > 0x3.
- output_data_q  output  WIDTH  output_data registered on the rising edge of clk.
- sel_err_q  output  1  sel_err registered on the rising edge of clk.

Behaviour:
- Combinational path, zero latency, no clock involvement:
  - signal 0x0 → d0; 0x1 → d1; 0x2 → d2; 0x3 → d3.
  - signal 0x4–0xF → output_data = 0 and sel_err = 1.
  - Otherwise sel_err = 0.
- Output must settle within the same cycle the inputs change. Verification samples it one clock edge after the inputs are applied.
- No latches: every select value has a defined output, including any X/Z decode default, which drives 0.
- Registered path:
  - On posedge clk: output_data_q <= output_data and sel_err_q <= sel_err, i.e. one-cycle latency.
  - While rst = 1, asynchronously: output_data_q = 0 and sel_err_q = 0, regardless of clk.
  - On rst deassertion, the registered outputs resume capture at the next posedge clk.
- rst has no effect on output_data or sel_err.
- Data is passed bit-exact: no sign extension, no arithmetic.
- When several inputs hold equal values, the output simply equals that value; no priority semantics apply.
- Changing signal and data in the same instant gives a glitch-free final value within the cycle. Transient glitches are acceptable.

Decomposition:
- Shared package holds the select-code constants:
  - SEL_D0 = 4'h0, SEL_D1 = 4'h1, SEL_D2 = 4'h2, SEL_D3 = 4'h3, SEL_MAX = 4'h3.
  - The default WIDTH of 32.
- One natural sub-module: mux4_sel_reg.
  - WIDTH+1-bit register with asynchronous active-high clear.
  - Holds output_data_q and sel_err_q.
- The decode and select logic stays in the top level.

Test Plan:
1. d0=0x11111111, d1=0x22222222, d2=0x33333333, d3=0x44444444; step signal through 0x0..0x3 → output_data equals 0x11111111, 0x22222222, 0x33333333, 0x44444444 in turn, with sel_err = 0, checked one clock after each apply.
2. All data inputs 0 with signal = 0x0 → output_data = 0x00000000. Then d2 = 0xFFFFFFFF with signal = 0x2 → 0xFFFFFFFF.
3. Illegal select: signal = 0x4, 0x8 and 0xF with nonzero data → output_data = 0 and sel_err = 1 for each.
4. Change d1 = 0xDEADBEEF to 0xCAFEBABE while signal = 0x1 → output_data follows within the same cycle. output_data_q shows 0xDEADBEEF until the next posedge, then 0xCAFEBABE.
5. Assert rst mid-cycle while output_data_q = 0x12345678 → output_data_q = 0 and sel_err_q = 0 immediately, with no clock edge needed. output_data is unchanged throughout.
6. Release rst → output_data_q captures the current selection at the first posedge after release.
